// File: rtl/vedic_mult_seq_if.sv
// vedic_mult_seq_if: operand/product valid-ready bundle for vedic_mult_seq.
// signed_mode exists only when VEDIC_SIGNED_EN is defined.
interface vedic_mult_seq_if #(
   parameter int WIDTH = 8
);
   logic in_valid;
   logic in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
`ifdef VEDIC_SIGNED_EN
   logic signed_mode;
`endif
   logic out_valid;
   logic out_ready;
   logic [2*WIDTH-1:0] product;
   logic busy;
   modport master (
`ifdef VEDIC_SIGNED_EN
      output signed_mode,
`endif
      output in_valid, a, b, out_ready,
      input in_ready, out_valid, product, busy
   );
   modport slave (
`ifdef VEDIC_SIGNED_EN
      input signed_mode,
`endif
      input in_valid, a, b, out_ready,
      output in_ready, out_valid, product, busy
   );
endinterface

// File: rtl/vedic_mult_seq.sv
// vedic_mult_seq: multi-cycle WIDTHxWIDTH multiplier, one 4x4 Vedic digit product per cycle.
// Optional two's-complement mode when VEDIC_SIGNED_EN is defined.
module vedic_mult_seq #(
   parameter int WIDTH = 8
) (
   input logic clk,
   input logic rst,
   vedic_mult_seq_if.slave bus_io
);
   localparam int N = WIDTH / 4;
   localparam int PW = 2 * WIDTH;
   localparam int CW = (N > 1) ? $clog2(N) : 1;
   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
   state_t state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d, a_mag, b_mag;
   logic [PW-1:0] acc_q, acc_d, product_q, product_d, term, sum;
   logic [CW-1:0] i_q, i_d, j_q, j_d;
   logic neg_q, neg_d, neg_in, last, j_wrap;
   logic [3:0] da, db;
   logic [7:0] core;
   function automatic logic [3:0] vedic2(input logic [1:0] x, input logic [1:0] y);
      logic c;
      c = x[1] & y[0] & x[0] & y[1];
      vedic2 = {x[1] & y[1] & c, (x[1] & y[1]) ^ c, (x[1] & y[0]) ^ (x[0] & y[1]), x[0] & y[0]};
   endfunction
   // vertical and crosswise 2x2 partials; the crosswise sum carries the low partial's high bits
   function automatic logic [7:0] vedic4(input logic [3:0] x, input logic [3:0] y);
      logic [3:0] q0, q1, q2, q3;
      logic [5:0] mid;
      q0 = vedic2(x[1:0], y[1:0]);
      q1 = vedic2(x[3:2], y[1:0]);
      q2 = vedic2(x[1:0], y[3:2]);
      q3 = vedic2(x[3:2], y[3:2]);
      mid = 6'(q1) + 6'(q2) + 6'(q0[3:2]);
      vedic4 = {4'(q3 + mid[5:2]), mid[1:0], q0[1:0]};
   endfunction
   always_comb begin
`ifdef VEDIC_SIGNED_EN
      a_mag = (bus_io.signed_mode && bus_io.a[WIDTH-1]) ? -bus_io.a : bus_io.a;
      b_mag = (bus_io.signed_mode && bus_io.b[WIDTH-1]) ? -bus_io.b : bus_io.b;
      neg_in = bus_io.signed_mode && (bus_io.a[WIDTH-1] ^ bus_io.b[WIDTH-1]);
`else
      a_mag = bus_io.a;
      b_mag = bus_io.b;
      neg_in = 1'b0;
`endif
      da = a_q[4*i_q +: 4];
      db = b_q[4*j_q +: 4];
      core = vedic4(da, db);
      term = PW'(core) << (4 * (int'(i_q) + int'(j_q)));
      sum = acc_q + term;
      j_wrap = int'(j_q) == N - 1;
      last = j_wrap && (int'(i_q) == N - 1);
      state_d = state_q;
      a_d = a_q;
      b_d = b_q;
      neg_d = neg_q;
      acc_d = acc_q;
      product_d = product_q;
      i_d = i_q;
      j_d = j_q;
      case (state_q)
         IDLE: if (bus_io.in_valid) begin
            state_d = CALC;
            a_d = a_mag;
            b_d = b_mag;
            neg_d = neg_in;
            acc_d = '0;
            i_d = '0;
            j_d = '0;
         end
         CALC: begin
            acc_d = sum;
            j_d = j_wrap ? '0 : j_q + 1'b1;
            i_d = j_wrap ? i_q + 1'b1 : i_q;
            if (last) begin
               state_d = DONE;
               product_d = neg_q ? -sum : sum;
               i_d = '0;
               j_d = '0;
            end
         end
         DONE: state_d = bus_io.out_ready ? IDLE : DONE;
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         a_q <= '0;
         b_q <= '0;
         neg_q <= 1'b0;
         acc_q <= '0;
         product_q <= '0;
         i_q <= '0;
         j_q <= '0;
      end else begin
         state_q <= state_d;
         a_q <= a_d;
         b_q <= b_d;
         neg_q <= neg_d;
         acc_q <= acc_d;
         product_q <= product_d;
         i_q <= i_d;
         j_q <= j_d;
      end
   end
   assign bus_io.in_ready = state_q == IDLE;
   assign bus_io.out_valid = state_q == DONE;
   assign bus_io.busy = state_q != IDLE;
   assign bus_io.product = product_q;
endmodule

// File: tb/tb_vedic_mult_seq.sv
// tb_vedic_mult_seq: scoreboard bench for vedic_mult_seq at WIDTH=8 and WIDTH=16.
module tb_vedic_mult_seq;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int vectors = 0;
   int miscompares = 0;
   logic [15:0] sb8[$];
   logic [31:0] sb16[$];
   vedic_mult_seq_if #(.WIDTH(8)) i8();
   vedic_mult_seq_if #(.WIDTH(16)) i16();
   vedic_mult_seq #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus_io(i8.slave));
   vedic_mult_seq #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .bus_io(i16.slave));
   always #5 clk = ~clk;
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
   function automatic logic [15:0] model8(input logic [7:0] x, input logic [7:0] y, input logic sm);
      int sx, sy;
      sx = sm ? int'($signed(x)) : int'(x);
      sy = sm ? int'($signed(y)) : int'(y);
      return 16'(sx * sy);
   endfunction
   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask
   task automatic run8(input logic [7:0] x, input logic [7:0] y, input logic sm, input string nm);
      int n = 0;
      logic [15:0] e;
      while (!i8.in_ready && n < 50) begin
         step();
         n++;
      end
      vectors++;
      if (i8.in_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL %s in_ready before accept: got %b want 1", nm, i8.in_ready);
      end
      i8.a = x;
      i8.b = y;
      i8.in_valid = 1'b1;
      i8.out_ready = 1'b1;
`ifdef VEDIC_SIGNED_EN
      i8.signed_mode = sm;
`endif
      sb8.push_back(model8(x, y, sm));
      step();
      i8.in_valid = 1'b0;
      i8.a = ~x;
      i8.b = ~y;
      n = 0;
      while (!i8.out_valid && n < 100) begin
         step();
         n++;
      end
      vectors++;
      if (n !== 4) begin
         miscompares++;
         $display("FAIL %s latency: got %0d edges want 4", nm, n);
      end
      e = sb8.pop_front();
      vectors++;
      if (i8.product !== e) begin
         miscompares++;
         $display("FAIL %s product: got %h want %h", nm, i8.product, e);
      end
      step();
      vectors++;
      if (i8.out_valid !== 1'b0 || i8.in_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL %s handoff: got out_valid=%b in_ready=%b want 0/1", nm, i8.out_valid, i8.in_ready);
      end
   endtask
   task automatic run16(input logic [15:0] x, input logic [15:0] y, input string nm);
      int n = 0;
      logic [31:0] e;
      vectors++;
      if (i16.in_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL %s in_ready before accept: got %b want 1", nm, i16.in_ready);
      end
      i16.a = x;
      i16.b = y;
      i16.in_valid = 1'b1;
      i16.out_ready = 1'b1;
      sb16.push_back(32'(x) * 32'(y));
      step();
      i16.in_valid = 1'b0;
      i16.a = '0;
      i16.b = '0;
      while (!i16.out_valid && n < 300) begin
         step();
         n++;
      end
      vectors++;
      if (n !== 16) begin
         miscompares++;
         $display("FAIL %s latency: got %0d edges want 16", nm, n);
      end
      e = sb16.pop_front();
      vectors++;
      if (i16.product !== e) begin
         miscompares++;
         $display("FAIL %s product: got %h want %h", nm, i16.product, e);
      end
      step();
      vectors++;
      if (i16.out_valid !== 1'b0 || i16.in_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL %s handoff: got out_valid=%b in_ready=%b want 0/1", nm, i16.out_valid, i16.in_ready);
      end
   endtask
   task automatic test_reset();
      rst = 1'b1;
      step();
      step();
      vectors++;
      if ({i8.in_ready, i8.out_valid, i8.busy} !== 3'b100) begin
         miscompares++;
         $display("FAIL reset8 flags: got in_ready/out_valid/busy=%b want 100", {i8.in_ready, i8.out_valid, i8.busy});
      end
      vectors++;
      if (i8.product !== 16'h0000) begin
         miscompares++;
         $display("FAIL reset8 product: got %h want 0000", i8.product);
      end
      vectors++;
      if ({i16.in_ready, i16.out_valid, i16.busy} !== 3'b100 || i16.product !== 32'h0) begin
         miscompares++;
         $display("FAIL reset16: got flags=%b product=%h want 100/0", {i16.in_ready, i16.out_valid, i16.busy}, i16.product);
      end
      rst = 1'b0;
      step();
   endtask
   task automatic test_basic();
      run8(8'd13, 8'd11, 1'b0, "13x11");
      run8(8'hFF, 8'hFF, 1'b0, "FFxFF");
      run8(8'h00, 8'hA5, 1'b0, "00xA5");
      run8(8'h80, 8'h01, 1'b0, "80x01");
      run8(8'h10, 8'h10, 1'b0, "10x10");
   endtask
   task automatic test_backpressure();
      int n = 0;
      logic [15:0] e;
      i8.out_ready = 1'b0;
      i8.a = 8'h37;
      i8.b = 8'h5C;
      i8.in_valid = 1'b1;
      sb8.push_back(model8(8'h37, 8'h5C, 1'b0));
      step();
      i8.in_valid = 1'b0;
      while (!i8.out_valid && n < 100) begin
         step();
         n++;
      end
      e = sb8[0];
      for (int k = 0; k < 10; k++) begin
         i8.in_valid = k[0];
         i8.a = 8'($urandom);
         i8.b = 8'($urandom);
         step();
         vectors++;
         if (i8.out_valid !== 1'b1 || i8.in_ready !== 1'b0 || i8.busy !== 1'b1) begin
            miscompares++;
            $display("FAIL backpressure flags cycle %0d: got out_valid/in_ready/busy=%b want 101", k, {i8.out_valid, i8.in_ready, i8.busy});
         end
         vectors++;
         if (i8.product !== e) begin
            miscompares++;
            $display("FAIL backpressure hold cycle %0d: got %h want %h", k, i8.product, e);
         end
      end
      i8.in_valid = 1'b0;
      i8.out_ready = 1'b1;
      e = sb8.pop_front();
      vectors++;
      if (i8.product !== e) begin
         miscompares++;
         $display("FAIL backpressure product: got %h want %h", i8.product, e);
      end
      step();
      vectors++;
      if ({i8.out_valid, i8.in_ready, i8.busy} !== 3'b010) begin
         miscompares++;
         $display("FAIL backpressure release: got out_valid/in_ready/busy=%b want 010", {i8.out_valid, i8.in_ready, i8.busy});
      end
   endtask
   task automatic test_mid_reset();
      i8.out_ready = 1'b1;
      i8.a = 8'd9;
      i8.b = 8'd9;
      i8.in_valid = 1'b1;
      step();
      i8.in_valid = 1'b0;
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      vectors++;
      if ({i8.out_valid, i8.in_ready, i8.busy} !== 3'b010 || i8.product !== 16'h0000) begin
         miscompares++;
         $display("FAIL mid_reset: got flags=%b product=%h want 010/0000", {i8.out_valid, i8.in_ready, i8.busy}, i8.product);
      end
      run8(8'd6, 8'd7, 1'b0, "6x7_after_reset");
      rst = 1'b1;
      i8.in_valid = 1'b1;
      i8.a = 8'd3;
      i8.b = 8'd3;
      step();
      rst = 1'b0;
      i8.in_valid = 1'b0;
      step();
      vectors++;
      if (i8.busy !== 1'b0 || i8.in_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL rst_with_in_valid: got busy=%b in_ready=%b want 0/1", i8.busy, i8.in_ready);
      end
   endtask
   task automatic test_back_to_back();
      int sent = 0;
      int last = -1;
      int cyc = 0;
      logic took;
      logic [15:0] e;
`ifdef VEDIC_SIGNED_EN
      i8.signed_mode = 1'b0;
`endif
      i8.out_ready = 1'b1;
      i8.in_valid = 1'b1;
      i8.a = 8'hFF;
      i8.b = 8'h01;
      while ((sent < 20 || sb8.size() > 0) && cyc < 1000) begin
         took = 1'b0;
         if (i8.out_valid && sb8.size() > 0) begin
            e = sb8.pop_front();
            vectors++;
            if (i8.product !== e) begin
               miscompares++;
               $display("FAIL b2b product: got %h want %h", i8.product, e);
            end
         end
         if (i8.in_ready && i8.in_valid) begin
            sb8.push_back(model8(i8.a, i8.b, 1'b0));
            if (last >= 0) begin
               vectors++;
               if (cyc - last !== 6) begin
                  miscompares++;
                  $display("FAIL b2b spacing: got %0d cycles want 6", cyc - last);
               end
            end
            last = cyc;
            sent++;
            took = 1'b1;
         end
         step();
         cyc++;
         if (took) begin
            i8.a = 8'($urandom);
            i8.b = 8'($urandom);
            i8.in_valid = sent < 20;
         end
      end
      vectors++;
      if (cyc >= 1000) begin
         miscompares++;
         $display("FAIL b2b timeout: got %0d sent, %0d pending want 20/0", sent, sb8.size());
      end
   endtask
   task automatic test_wide16();
      run16(16'hFFFF, 16'hFFFF, "w16_FFFFxFFFF");
      run16(16'h1234, 16'hABCD, "w16_1234xABCD");
      run16(16'h8001, 16'h0003, "w16_8001x0003");
      run16(16'($urandom), 16'($urandom), "w16_random");
   endtask
`ifdef VEDIC_SIGNED_EN
   task automatic test_signed();
      run8(8'hFD, 8'h05, 1'b1, "s_m3x5");
      run8(8'h80, 8'h80, 1'b1, "s_80x80");
      run8(8'h7F, 8'h80, 1'b1, "s_7Fx80");
      run8(8'hFF, 8'hFF, 1'b1, "s_m1xm1");
      run8(8'h00, 8'h80, 1'b1, "s_0x80");
      run8(8'hFD, 8'h05, 1'b0, "u_FDx05");
   endtask
`endif
   initial begin
      i8.in_valid = 1'b0;
      i8.out_ready = 1'b0;
      i8.a = '0;
      i8.b = '0;
      i16.in_valid = 1'b0;
      i16.out_ready = 1'b0;
      i16.a = '0;
      i16.b = '0;
`ifdef VEDIC_SIGNED_EN
      i8.signed_mode = 1'b0;
      i16.signed_mode = 1'b0;
`endif
      test_reset();
      test_basic();
      test_backpressure();
      test_mid_reset();
      test_back_to_back();
      test_wide16();
`ifdef VEDIC_SIGNED_EN
      test_signed();
`endif
      vectors++;
      if (sb8.size() !== 0 || sb16.size() !== 0) begin
         miscompares++;
         $display("FAIL scoreboard residue: got %0d/%0d entries want 0/0", sb8.size(), sb16.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
